// File: rtl/dual_issue_dispatch_pkg.sv
// Shared definitions for the dual-issue dispatcher: decoded-word layout,
// NOP encoding, pipe tags, FSM states and scoreboard geometry.
package dual_issue_dispatch_pkg;

   localparam int DEC_W    = 79;
   localparam int REG_W    = 7;
   localparam int W_FULL   = 32;
   localparam int W_ID     = 7;
   localparam int W_UNIT   = 3;
   localparam int W_LAT    = 4;
   localparam int W_SRC    = 3;

   localparam int OFF_FULL = 0;
   localparam int OFF_ID   = 32;
   localparam int OFF_DST  = 39;
   localparam int OFF_UNIT = 46;
   localparam int OFF_LAT  = 49;
   localparam int OFF_WR   = 53;
   localparam int OFF_PIPE = 54;
   localparam int OFF_RA   = 55;
   localparam int OFF_RB   = 62;
   localparam int OFF_RC   = 69;
   localparam int OFF_SRC  = 76;   // src_used: first bit ra, then rb, then rc

   localparam logic [W_ID-1:0] NOP_ID    = 7'h7F;
   localparam logic            PIPE_EVEN = 1'b0;
   localparam logic            PIPE_ODD  = 1'b1;

   localparam int SB_DEPTH = 128;
   localparam int SB_CTR_W = 4;

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'b00,
      ST_HOLD_PAIR = 2'b01,
      ST_HOLD_B    = 2'b10
   } state_e;

   typedef logic [0:DEC_W-1] dec_word_t;

   typedef struct packed {
      logic [W_FULL-1:0] full_instr;
      logic [W_ID-1:0]   instr_id;
      logic [REG_W-1:0]  reg_dst;
      logic [W_UNIT-1:0] unit_id;
      logic [W_LAT-1:0]  latency;
      logic              reg_wr;
      logic [REG_W-1:0]  ra_addr;
      logic [REG_W-1:0]  rb_addr;
      logic [REG_W-1:0]  rc_addr;
   } out_t;

   function automatic logic [REG_W-1:0] f_dst(input dec_word_t w);
      return w[OFF_DST +: REG_W];
   endfunction

   function automatic logic [W_LAT-1:0] f_lat(input dec_word_t w);
      return w[OFF_LAT +: W_LAT];
   endfunction

   function automatic logic f_wr(input dec_word_t w);
      return w[OFF_WR];
   endfunction

   function automatic logic f_pipe(input dec_word_t w);
      return w[OFF_PIPE];
   endfunction

   // k = 0/1/2 selects ra/rb/rc
   function automatic logic [REG_W-1:0] f_src(input dec_word_t w, input int k);
      return w[OFF_RA + k*REG_W +: REG_W];
   endfunction

   function automatic logic f_used(input dec_word_t w, input int k);
      return w[OFF_SRC + k];
   endfunction

   function automatic out_t to_out(input dec_word_t w);
      out_t o;
      o.full_instr = w[OFF_FULL +: W_FULL];
      o.instr_id   = w[OFF_ID +: W_ID];
      o.reg_dst    = w[OFF_DST +: REG_W];
      o.unit_id    = w[OFF_UNIT +: W_UNIT];
      o.latency    = w[OFF_LAT +: W_LAT];
      o.reg_wr     = w[OFF_WR];
      o.ra_addr    = w[OFF_RA +: REG_W];
      o.rb_addr    = w[OFF_RB +: REG_W];
      o.rc_addr    = w[OFF_RC +: REG_W];
      return o;
   endfunction

   function automatic out_t nop_out();
      out_t o;
      o          = '{default: 1'b0};
      o.instr_id = NOP_ID;
      return o;
   endfunction

endpackage

// File: rtl/dual_issue_dispatch_scoreboard.sv
// Register-busy scoreboard: one down-counter per architectural register,
// six combinational read ports and two load ports (load beats decrement).
module spu_scoreboard
   import dual_issue_dispatch_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [6*REG_W-1:0]        rd_addr,
   output logic [6*SB_CTR_W-1:0]     rd_data,
   input  logic                      ld0_en,
   input  logic [REG_W-1:0]          ld0_addr,
   input  logic [SB_CTR_W-1:0]       ld0_val,
   input  logic                      ld1_en,
   input  logic [REG_W-1:0]          ld1_addr,
   input  logic [SB_CTR_W-1:0]       ld1_val
);

   logic [SB_CTR_W-1:0] ctr_r [SB_DEPTH];

   // read ports
   always_comb begin
      rd_data = {(6*SB_CTR_W){1'b0}};
      for (int k = 0; k < 6; k++) begin
         rd_data[k*SB_CTR_W +: SB_CTR_W] = ctr_r[rd_addr[k*REG_W +: REG_W]];
      end
   end

   // counter update: loads win over the per-cycle decrement
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            ctr_r[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            if (ld1_en && ld1_addr == 7'(i)) begin
               ctr_r[i] <= ld1_val;
            end else if (ld0_en && ld0_addr == 7'(i)) begin
               ctr_r[i] <= ld0_val;
            end else if (ctr_r[i] != 4'd0) begin
               ctr_r[i] <= ctr_r[i] - 4'd1;
            end else begin
               ctr_r[i] <= ctr_r[i];
            end
         end
      end
   end

endmodule

// File: rtl/dual_issue_dispatch.sv
// Two-slot in-order dispatcher: buffers a decoded pair, issues A and B to
// the even/odd pipes subject to scoreboard and intra-pair hazards.
module dual_issue_dispatch
   import dual_issue_dispatch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [0:78] dec_a,
   input  logic [0:78] dec_b,
   input  logic        flush,
   output logic [0:31] full_instr_even,
   output logic [0:6]  instr_id_even,
   output logic [0:6]  reg_dst_even,
   output logic [0:2]  unit_id_even,
   output logic [0:3]  latency_even,
   output logic        reg_wr_even,
   output logic [0:6]  ra_addr_even,
   output logic [0:6]  rb_addr_even,
   output logic [0:6]  rc_addr_even,
   output logic [0:31] full_instr_odd,
   output logic [0:6]  instr_id_odd,
   output logic [0:6]  reg_dst_odd,
   output logic [0:2]  unit_id_odd,
   output logic [0:3]  latency_odd,
   output logic        reg_wr_odd,
   output logic [0:6]  ra_addr_odd,
   output logic [0:6]  rb_addr_odd,
   output logic [0:6]  rc_addr_odd,
   output logic [0:15] stall_count
);

   state_e                 state_r;
   dec_word_t              a_r, b_r;
   out_t                   out_even_r, out_odd_r;
   out_t                   next_even_s, next_odd_s;
   logic [15:0]            stall_r;
   logic [6*REG_W-1:0]     rd_addr_s;
   logic [6*SB_CTR_W-1:0]  rd_data_s;
   logic a_haz_s, b_haz_s, b_raw_s, b_waw_s, pair_ok_s;
   logic a_issue_s, b_issue_s, all_issue_s, hs_s, ld0_en_s, ld1_en_s;

   spu_scoreboard u_sb (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr_s),
      .rd_data  (rd_data_s),
      .ld0_en   (ld0_en_s),
      .ld0_addr (f_dst(a_r)),
      .ld0_val  (f_lat(a_r)),
      .ld1_en   (ld1_en_s),
      .ld1_addr (f_dst(b_r)),
      .ld1_val  (f_lat(b_r))
   );

   // scoreboard read addresses: ports 0-2 for A, 3-5 for B
   always_comb begin
      rd_addr_s = {(6*REG_W){1'b0}};
      for (int k = 0; k < 3; k++) begin
         rd_addr_s[k*REG_W +: REG_W]     = f_src(a_r, k);
         rd_addr_s[(k+3)*REG_W +: REG_W] = f_src(b_r, k);
      end
   end

   // hazard detection and issue decision
   always_comb begin
      a_haz_s = 1'b0;
      b_haz_s = 1'b0;
      b_raw_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_haz_s = a_haz_s | (f_used(a_r, k) & (rd_data_s[k*SB_CTR_W +: SB_CTR_W] != 4'd0));
         b_haz_s = b_haz_s | (f_used(b_r, k) & (rd_data_s[(k+3)*SB_CTR_W +: SB_CTR_W] != 4'd0));
         b_raw_s = b_raw_s | (f_used(b_r, k) & f_wr(a_r) & (f_src(b_r, k) == f_dst(a_r)));
      end
      b_waw_s   = f_wr(a_r) & f_wr(b_r) & (f_dst(a_r) == f_dst(b_r));
      pair_ok_s = (f_pipe(a_r) != f_pipe(b_r)) & ~b_raw_s & ~b_waw_s & ~b_haz_s;
      case (state_r)
         ST_HOLD_PAIR: begin
            a_issue_s   = ~a_haz_s;
            b_issue_s   = ~a_haz_s & pair_ok_s;
            all_issue_s = ~a_haz_s & pair_ok_s;
         end
         ST_HOLD_B: begin
            a_issue_s   = 1'b0;
            b_issue_s   = ~b_haz_s;
            all_issue_s = ~b_haz_s;
         end
         default: begin
            a_issue_s   = 1'b0;
            b_issue_s   = 1'b0;
            all_issue_s = 1'b0;
         end
      endcase
      dec_ready = (state_r == ST_EMPTY) | (all_issue_s & ~flush);
      hs_s      = dec_valid & dec_ready & ~flush;
      ld0_en_s  = a_issue_s & ~flush & f_wr(a_r) & (f_lat(a_r) != 4'd0);
      ld1_en_s  = b_issue_s & ~flush & f_wr(b_r) & (f_lat(b_r) != 4'd0);
      next_even_s = (a_issue_s && f_pipe(a_r) == PIPE_EVEN) ? to_out(a_r) :
                    (b_issue_s && f_pipe(b_r) == PIPE_EVEN) ? to_out(b_r) : nop_out();
      next_odd_s  = (a_issue_s && f_pipe(a_r) == PIPE_ODD)  ? to_out(a_r) :
                    (b_issue_s && f_pipe(b_r) == PIPE_ODD)  ? to_out(b_r) : nop_out();
   end

   // pair-buffer FSM, issue registers and stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_EMPTY;
         a_r        <= {DEC_W{1'b0}};
         b_r        <= {DEC_W{1'b0}};
         out_even_r <= nop_out();
         out_odd_r  <= nop_out();
         stall_r    <= 16'd0;
      end else if (flush) begin
         state_r    <= ST_EMPTY;
         out_even_r <= nop_out();
         out_odd_r  <= nop_out();
      end else begin
         out_even_r <= next_even_s;
         out_odd_r  <= next_odd_s;
         if (state_r != ST_EMPTY && !all_issue_s && stall_r != 16'hFFFF) begin
            stall_r <= stall_r + 16'd1;
         end
         if (hs_s) begin
            a_r <= dec_a;
            b_r <= dec_b;
         end
         case (state_r)
            ST_HOLD_PAIR: state_r <= hs_s ? ST_HOLD_PAIR :
                                     all_issue_s ? ST_EMPTY :
                                     a_issue_s ? ST_HOLD_B : ST_HOLD_PAIR;
            ST_HOLD_B:    state_r <= hs_s ? ST_HOLD_PAIR :
                                     b_issue_s ? ST_EMPTY : ST_HOLD_B;
            default:      state_r <= hs_s ? ST_HOLD_PAIR : ST_EMPTY;
         endcase
      end
   end

   assign full_instr_even = out_even_r.full_instr;
   assign instr_id_even   = out_even_r.instr_id;
   assign reg_dst_even    = out_even_r.reg_dst;
   assign unit_id_even    = out_even_r.unit_id;
   assign latency_even    = out_even_r.latency;
   assign reg_wr_even     = out_even_r.reg_wr;
   assign ra_addr_even    = out_even_r.ra_addr;
   assign rb_addr_even    = out_even_r.rb_addr;
   assign rc_addr_even    = out_even_r.rc_addr;
   assign full_instr_odd  = out_odd_r.full_instr;
   assign instr_id_odd    = out_odd_r.instr_id;
   assign reg_dst_odd     = out_odd_r.reg_dst;
   assign unit_id_odd     = out_odd_r.unit_id;
   assign latency_odd     = out_odd_r.latency;
   assign reg_wr_odd      = out_odd_r.reg_wr;
   assign ra_addr_odd     = out_odd_r.ra_addr;
   assign rb_addr_odd     = out_odd_r.rb_addr;
   assign rc_addr_odd     = out_odd_r.rc_addr;
   assign stall_count     = stall_r;

endmodule
